// File: rtl/parallel_recv_check.sv
// Receive-side checker for the 32-bit parallel link test stream: hunts for the alignment word,
// self-seeds an expected-data counter and reports lock, error and frame statistics.
module parallel_recv_check #(
    parameter int unsigned FrameLen  = 1024,
    parameter logic [31:0] AlignWord = 32'h0000F731,
    parameter int unsigned GapMax    = 512,
    parameter int unsigned ErrLimit  = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        divalid_i,
    input  logic [31:0] din_i,
    output logic        locked_o,
    output logic        in_frame_o,
    output logic        err_o,
    output logic        frame_done_o,
    output logic [15:0] err_cnt_o,
    output logic [15:0] frame_cnt_o,
    output logic [7:0]  lock_loss_cnt_o
);
    localparam int unsigned WcW = $clog2(FrameLen + 1);
    localparam int unsigned GcW = $clog2(GapMax + 1);
    localparam int unsigned FeW = $clog2(ErrLimit + 1);

    typedef enum logic [1:0] {StHunt, StData, StGap} state_e;

    state_e         state_q, state_d;
    logic           seeded_q, seeded_d;
    logic           seed_pend_q, seed_pend_d;
    logic [WcW-1:0] word_cnt_q, word_cnt_d;
    logic [GcW-1:0] gap_cnt_q, gap_cnt_d;
    logic [FeW-1:0] frame_err_q, frame_err_d;
    logic [31:0]    expected_q, expected_d;
    logic           locked_q, in_frame_q, err_q, done_q;
    logic           err_d, done_d;
    logic [15:0]    err_cnt_q, err_cnt_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic [7:0]     loss_cnt_q, loss_cnt_d;

    always_comb begin
        state_d     = state_q;
        seeded_d    = seeded_q;
        seed_pend_d = seed_pend_q;
        word_cnt_d  = word_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        frame_err_d = frame_err_q;
        expected_d  = expected_q;
        err_d       = 1'b0;
        done_d      = 1'b0;
        err_cnt_d   = err_cnt_q;
        frame_cnt_d = frame_cnt_q;
        loss_cnt_d  = loss_cnt_q;

        if (divalid_i) begin
            unique case (state_q)
                StHunt: begin
                    if (din_i == AlignWord) begin
                        state_d     = StData;
                        word_cnt_d  = '0;
                        frame_err_d = '0;
                        seed_pend_d = 1'b1;
                    end
                end
                StData: begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (seed_pend_q) begin
                        expected_d  = din_i + 32'd1;
                        seed_pend_d = 1'b0;
                        seeded_d    = 1'b1;
                    end else begin
                        // Advance regardless of match so one corrupted word costs one error.
                        expected_d = expected_q + 32'd1;
                        if (din_i != expected_q) begin
                            err_d       = 1'b1;
                            frame_err_d = frame_err_q + 1'b1;
                            if (err_cnt_q != 16'hFFFF) begin
                                err_cnt_d = err_cnt_q + 16'd1;
                            end
                        end
                    end
                    if (word_cnt_d == WcW'(FrameLen)) begin
                        done_d      = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = StGap;
                        gap_cnt_d   = '0;
                    end
                    // Error limit overrides the move to GAP on the frame's last word.
                    if (err_d && frame_err_d == FeW'(ErrLimit)) begin
                        state_d  = StHunt;
                        seeded_d = 1'b0;
                        if (loss_cnt_q != 8'hFF) begin
                            loss_cnt_d = loss_cnt_q + 8'd1;
                        end
                    end
                end
                StGap: begin
                    if (din_i == AlignWord) begin
                        state_d     = StData;
                        word_cnt_d  = '0;
                        frame_err_d = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                        if (gap_cnt_d == GcW'(GapMax)) begin
                            state_d  = StHunt;
                            seeded_d = 1'b0;
                            if (loss_cnt_q != 8'hFF) begin
                                loss_cnt_d = loss_cnt_q + 8'd1;
                            end
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            state_q     <= StHunt;
            seeded_q    <= 1'b0;
            seed_pend_q <= 1'b0;
            word_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            frame_err_q <= '0;
            expected_q  <= '0;
            locked_q    <= 1'b0;
            in_frame_q  <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            err_cnt_q   <= '0;
            frame_cnt_q <= '0;
            loss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            seeded_q    <= seeded_d;
            seed_pend_q <= seed_pend_d;
            word_cnt_q  <= word_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            frame_err_q <= frame_err_d;
            expected_q  <= expected_d;
            locked_q    <= seeded_d && (state_d != StHunt);
            in_frame_q  <= (state_d == StData);
            err_q       <= err_d;
            done_q      <= done_d;
            err_cnt_q   <= err_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            loss_cnt_q  <= loss_cnt_d;
        end
    end

    assign locked_o        = locked_q;
    assign in_frame_o      = in_frame_q;
    assign err_o           = err_q;
    assign frame_done_o    = done_q;
    assign err_cnt_o       = err_cnt_q;
    assign frame_cnt_o     = frame_cnt_q;
    assign lock_loss_cnt_o = loss_cnt_q;

endmodule

// File: doc/parallel_recv_check.md
Name: parallel_recv_check

Overview:
- Receive-side checker for the 32-bit parallel link test stream.
- Consumes words from the link deserializer, qualified by DIVALID. Each frame is a training preamble (0x0000 / 0xAAAA words), one alignment word 0x0000F731, then FRAME_LEN incrementing data words.
- Hunts for the alignment word, self-seeds an expected-data counter, checks every data word and reports lock, error and frame statistics to the status/debug logic.

Parameters:
- FRAME_LEN, 1024, data words per frame after the alignment word.
- ALIGN_WORD, 32'h0000F731, alignment marker.
- GAP_MAX, 512, maximum valid non-alignment words tolerated between frames before lock is dropped.
- ERR_LIMIT, 16, data errors within one frame at which lock is dropped.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- CLR  in  1  synchronous clear; same effect as RST; RST has priority.
- DIVALID  in  1  DIN holds a valid word this cycle.
- DIN  in  32  received word.
- LOCKED  out  1  high in GAP and DATA after the first seeded frame.
- IN_FRAME  out  1  high while state is DATA.
- ERR  out  1  one-cycle pulse: the previous valid data word mismatched.
- FRAME_DONE  out  1  one-cycle pulse: the last data word of a frame was accepted.
- ERR_CNT  out  16  total data errors, saturates at 0xFFFF.
- FRAME_CNT  out  16  completed frames, wraps.
- LOCK_LOSS_CNT  out  8  lock drops, saturates at 0xFF.

Behaviour:
- Reset (RST or CLR): state=HUNT, seeded=0, word/gap counters=0, expected=0. All outputs are 0.
- Nothing changes on a cycle with DIVALID=0, except that the pulses ERR and FRAME_DONE return to 0.
- All outputs are registered. Responses appear on the cycle after the DIVALID word that causes them.
- HUNT state:
  - On a valid DIN==ALIGN_WORD: go to DATA, clear word_cnt and frame_err, set seed_pending=1.
  - Other valid words are ignored.
- DATA state:
  - Each valid word increments word_cnt.
  - If seed_pending: expected <= DIN+1, seed_pending=0, seeded=1. The word is never an error.
  - Otherwise compare DIN with expected.
    - On mismatch: pulse ERR, increment ERR_CNT (saturating) and frame_err.
    - expected <= expected+1 whether or not the word matched, so a single corrupted word costs one error.
  - expected is a 32-bit register and wraps 0xFFFFFFFF->0 without error.
  - When the accepted word is number FRAME_LEN:
    - Pulse FRAME_DONE, increment FRAME_CNT.
    - Go to GAP with gap_cnt=0.
    - The frame_err limit check takes priority: if it trips on this same word, go to HUNT and still pulse FRAME_DONE.
  - If frame_err reaches ERR_LIMIT: go to HUNT, seeded=0, increment LOCK_LOSS_CNT (saturating).
- GAP state:
  - A valid ALIGN_WORD goes to DATA, clears word_cnt and frame_err, and does not seed. Expected continues across frames, because the sender's data counter is not reset between frames.
  - Any other valid word increments gap_cnt.
  - When gap_cnt reaches GAP_MAX: go to HUNT, seeded=0, increment LOCK_LOSS_CNT.
- ALIGN_WORD arriving inside DATA is treated as ordinary data and compared, with no resync.
- LOCKED = seeded && state!=HUNT.
- IN_FRAME = (state==DATA).
- Boundary cases:
  - FRAME_LEN=1: the seed word alone completes the frame.
  - ERR_CNT holds at 0xFFFF.
  - RST/CLR mid-frame aborts immediately; the next frame re-seeds from HUNT.

Test Plan:
- Reset, then 256 training words (0/0xAAAA), F731, data 1..1024, with DIVALID=1 throughout:
  - LOCKED rises the cycle after data word 1.
  - FRAME_DONE pulses once, after word 1024.
  - FRAME_CNT=1, ERR_CNT=0.
- Two back-to-back frames (data 1..1024, then 256 training words, F731, 1025..2048), with random DIVALID gaps:
  - FRAME_CNT=2, ERR_CNT=0, LOCKED stays 1.
- Frame 2 with word 1500 replaced by 0xDEADBEEF:
  - A single ERR pulse, the cycle after that word.
  - ERR_CNT=1; word 1501 passes.
- 16 corrupted words in one frame:
  - LOCKED falls after the 16th, LOCK_LOSS_CNT=1, state HUNT.
  - The next F731 plus data 5000.. re-seeds, with no new errors.
- After lock, 512 training words without F731:
  - LOCKED drops, LOCK_LOSS_CNT increments.
- CLR asserted at data word 300:
  - Next cycle all outputs are 0.
  - Re-acquires on the next F731, seeding from its following word.
- Data wrap 0xFFFFFFFE..0x00000001: no ERR.
